ets_frame_reader: RTL

Read-side drain engine for the ETS triple buffer, in the `sys_clk` domain. When the buffer controller reports a complete frame (`r_valid`), it reads all `MAX_TAP` words through the buffer read port and streams them out as an AXI-Stream master. It then pulses `r_finish` to release the read buffer back to the controller. It is the consumer counterpart of the shifting-clock frame writer.

---
 rtl/ets_frame_reader_if.sv | 25 ++
 rtl/ets_frame_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ets_frame_reader_if.sv
// ets_frame_reader_if: buffer read port plus AXI-Stream master bundle.
// The DUT side is master; the buffer/sink side is slave.
interface ets_frame_reader_if;
  logic        r_valid;
  logic [8:0]  raddr;
  logic        r_occur;
  logic [31:0] rdata;
  logic        r_finish;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    input  r_valid, rdata, m_tready,
    output raddr, r_occur, r_finish,
    output m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output r_valid, rdata, m_tready,
    input  raddr, r_occur, r_finish,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/ets_frame_reader.sv
// ets_frame_reader: drains a complete triple-buffer frame as AXI-Stream,
// then pulses r_finish to hand the read buffer back to the controller.
module ets_frame_reader #(
  parameter int MAX_TAP      = 448,
  parameter int RELEASE_WAIT = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        en,
  input  logic        oneshot,
  ets_frame_reader_if.master bus,
  output logic        busy,
  output logic [31:0] frames_sent
);
  localparam int WW = $clog2(RELEASE_WAIT + 1);
  localparam logic [8:0] LAST = 9'(MAX_TAP - 1);
  localparam logic [WW-1:0] WAIT_LD = WW'(RELEASE_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RELEASE
  } state_t;

  state_t        state_q;
  logic [8:0]    rd_ptr_q;
  logic [8:0]    beat_q;
  logic [WW-1:0] wait_q;
  logic          done_once_q;
  logic          r_finish_q;
  logic [31:0]   frames_q;

  logic [31:0]   mem_q [2];
  logic          wp_q;
  logic          rp_q;
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;
  logic          inflight_q;

  logic          pop;
  logic          push;
  logic          rd_issue;
  logic [2:0]    level;

  assign pop   = bus.m_tvalid & bus.m_tready;
  assign push  = inflight_q;
  assign level = {1'b0, occ_q} + {2'b00, inflight_q};

  // A read may only be issued if its word is guaranteed a FIFO slot.
  assign rd_issue = (state_q == READ) &&
                    (level < (3'd2 + {2'b00, pop}));

  assign bus.raddr    = rd_ptr_q;
  assign bus.r_occur  = rd_issue;
  assign bus.r_finish = r_finish_q;
  assign bus.m_tdata  = mem_q[rp_q];
  assign bus.m_tvalid = (occ_q != 2'd0);
  assign bus.m_tlast  = (occ_q != 2'd0) && (beat_q == LAST);
  assign busy         = (state_q != IDLE);
  assign frames_sent  = frames_q;

  // Occupancy follows the write one cycle behind each issued read.
  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      push && !pop: occ_d = occ_q + 2'd1;
      !push && pop: occ_d = occ_q - 2'd1;
      default:      occ_d = occ_q;
    endcase
  end

  // Two-entry output FIFO and read-return tracking.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (push) begin
        mem_q[wp_q] <= bus.rdata;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      occ_q <= occ_d;
    end
  end

  // Frame sequencing, beat count, release pulse and oneshot gating.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      done_once_q <= 1'b0;
      r_finish_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      r_finish_q <= 1'b0;
      if (pop) begin
        beat_q <= beat_q + 9'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (en && bus.r_valid && !done_once_q) begin
            state_q  <= READ;
            rd_ptr_q <= '0;
          end
        end
        READ: begin
          if (rd_issue) begin
            if (rd_ptr_q == LAST) begin
              state_q  <= DRAIN;
              rd_ptr_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + 9'd1;
            end
          end
        end
        DRAIN: begin
          if (pop && bus.m_tlast) begin
            state_q    <= RELEASE;
            r_finish_q <= 1'b1;
            wait_q     <= WAIT_LD;
            frames_q   <= frames_q + 32'd1;
            if (oneshot) begin
              done_once_q <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (wait_q == '0) begin
            state_q <= IDLE;
            beat_q  <= '0;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (!en) begin
        done_once_q <= 1'b0;
      end
    end
  end

  // The read throttle must make FIFO overflow impossible.
  a_no_overflow: assert property (
    @(posedge sys_clk) disable iff (reset)
    !(push && !pop && (occ_q == 2'd2))
  );
endmodule
